// File: rtl/crash_detect.sv
// Per-pixel collision detector between the enemy layers, my bullets and my plane.
// Crash pulses are combinational at the current scan position and rate-limited
// to one per type per frame. The block also tracks my-plane lives with an
// invincibility window and accumulates a saturating score.
module crash_detect #(
    parameter int unsigned NUM_TYPES      = 3,
    parameter int unsigned MAX_LIVES      = 3,
    parameter int unsigned LIFE_BIT_LEN   = 2,
    parameter int unsigned INVINC_FRAMES  = 120,
    parameter int unsigned INVINC_BIT_LEN = 7,
    parameter int unsigned SCORE_WIDTH    = 16,
    parameter int unsigned SCORE_STEP     = 1
) (
    input  logic                      clk_vga,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      v_sync_i,
    input  logic [NUM_TYPES-1:0]      enemy_alpha_i,
    input  logic                      bullet_alpha_i,
    input  logic                      me_alpha_i,
    output logic [NUM_TYPES-1:0]      crash_enemy_bullet_o,
    output logic [NUM_TYPES-1:0]      crash_me_enemy_o,
    output logic                      crash_bullet_o,
    output logic                      me_invincible_o,
    output logic [LIFE_BIT_LEN-1:0]   lives_o,
    output logic [SCORE_WIDTH-1:0]    score_o,
    output logic                      game_over_o
);

    localparam int unsigned CNT_W = $clog2(NUM_TYPES + 1);
    localparam int unsigned SUM_W = SCORE_WIDTH + 1;

    typedef enum logic [1:0] {
        ME_ALIVE  = 2'd0,
        ME_INVINC = 2'd1,
        ME_DEAD   = 2'd2
    } me_state_t;

    me_state_t                 me_state, me_state_n;
    logic                      v_sync_q;
    logic                      frame_start;
    logic [NUM_TYPES-1:0]      bul_armed, bul_armed_n;
    logic [NUM_TYPES-1:0]      me_armed, me_armed_n;
    logic [LIFE_BIT_LEN-1:0]   lives_q, lives_n;
    logic [INVINC_BIT_LEN-1:0] inv_cnt, inv_cnt_n;
    logic                      inv_q;
    logic                      game_over_q;
    logic [SCORE_WIDTH-1:0]    score_q, score_n;
    logic [CNT_W-1:0]          hit_cnt;
    logic [SUM_W-1:0]          score_sum;

    // Falling edge of the active-low vertical sync marks a new frame
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) v_sync_q <= 1'b1;
        else     v_sync_q <= v_sync_i;
    end

    assign frame_start = v_sync_q & ~v_sync_i;

    // Zero-latency crash pulses from the current-pixel alphas
    always_comb begin
        crash_enemy_bullet_o = {NUM_TYPES{~rst & en_i & bullet_alpha_i}}
                               & bul_armed & enemy_alpha_i;
        crash_me_enemy_o     = {NUM_TYPES{~rst & en_i & me_alpha_i & (me_state == ME_ALIVE)}}
                               & me_armed & enemy_alpha_i;
        crash_bullet_o       = |crash_enemy_bullet_o;
    end

    // Arm flags: re-armed each frame (wins over a same-cycle clear), cleared by a pulse
    always_comb begin
        bul_armed_n = bul_armed;
        me_armed_n  = me_armed;
        if (en_i) begin
            if (frame_start) begin
                bul_armed_n = '1;
                me_armed_n  = '1;
            end else begin
                bul_armed_n = bul_armed & ~crash_enemy_bullet_o;
                me_armed_n  = me_armed & ~crash_me_enemy_o;
            end
        end
    end

    // Saturating score update from the number of bullet hits this cycle
    always_comb begin
        hit_cnt = '0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            hit_cnt = hit_cnt + CNT_W'(crash_enemy_bullet_o[k]);
        end
        score_sum = {1'b0, score_q} + (SUM_W'(hit_cnt) * SUM_W'(SCORE_STEP));
        score_n   = score_q;
        if (en_i) begin
            score_n = score_sum[SUM_W-1] ? '1 : score_sum[SCORE_WIDTH-1:0];
        end
    end

    // My-plane next state: lose a life on a body hit, then wait out invincibility
    always_comb begin
        me_state_n = me_state;
        lives_n    = lives_q;
        inv_cnt_n  = inv_cnt;
        if (en_i) begin
            case (me_state)
                ME_ALIVE: begin
                    if (|crash_me_enemy_o) begin
                        lives_n = lives_q - LIFE_BIT_LEN'(1);
                        if (lives_n == '0) begin
                            me_state_n = ME_DEAD;
                        end else begin
                            me_state_n = ME_INVINC;
                            inv_cnt_n  = '0;
                        end
                    end
                end
                ME_INVINC: begin
                    if (frame_start) begin
                        if (inv_cnt == INVINC_BIT_LEN'(INVINC_FRAMES - 1)) begin
                            me_state_n = ME_ALIVE;
                        end else begin
                            inv_cnt_n = inv_cnt + INVINC_BIT_LEN'(1);
                        end
                    end
                end
                ME_DEAD: begin
                    me_state_n = ME_DEAD;
                end
                default: begin
                    me_state_n = ME_ALIVE;
                end
            endcase
        end
    end

    // State registers; status flags follow the next state so they match me_state
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            me_state    <= ME_ALIVE;
            bul_armed   <= '1;
            me_armed    <= '1;
            lives_q     <= LIFE_BIT_LEN'(MAX_LIVES);
            inv_cnt     <= '0;
            inv_q       <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
        end else begin
            me_state    <= me_state_n;
            bul_armed   <= bul_armed_n;
            me_armed    <= me_armed_n;
            lives_q     <= lives_n;
            inv_cnt     <= inv_cnt_n;
            inv_q       <= (me_state_n == ME_INVINC);
            game_over_q <= (me_state_n == ME_DEAD);
            score_q     <= score_n;
        end
    end

    assign me_invincible_o = inv_q;
    assign game_over_o     = game_over_q;
    assign lives_o         = lives_q;
    assign score_o         = score_q;

endmodule
